// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_rx
//  Purpose  : Assembles UART bytes into fixed-length frames (LSB byte first)
//             and hands them to the core through a valid/ack holding register.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frame_rx #(
    parameter int FRAME_BYTES    = 5,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TW             = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_read_done,
    input  logic [7:0]               read_data,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ack,
    input  logic                     clear_err,
    output logic                     overrun,
    output logic                     timeout_err,
    output logic [2:0]               byte_cnt,
    output logic                     sta
);

    localparam int              FW         = 8 * FRAME_BYTES;
    localparam logic [2:0]      LAST_IDX   = 3'(FRAME_BYTES - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   asm_q, asm_d;
    logic [FW-1:0]   frame_data_q, frame_data_d;
    logic            frame_valid_q, frame_valid_d;
    logic            overrun_q, overrun_d;
    logic            timeout_err_q, timeout_err_d;

    logic [FW-1:0]   w_merged;
    logic            w_complete;
    logic            w_timeout_hit;
    logic            w_overrun_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            timer_q       <= '0;
            asm_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            timer_q       <= timer_d;
            asm_q         <= asm_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        timer_d       = timer_q;
        asm_d         = asm_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        w_complete    = 1'b0;
        w_overrun_set = 1'b0;
        w_timeout_hit = 1'b0;

        // Current byte dropped into its slot; on the last byte this is the full frame.
        w_merged = asm_q;
        for (int k = 0; k < FRAME_BYTES; k++) begin
            if (byte_cnt_q == 3'(k)) begin
                w_merged[8*k +: 8] = read_data;
            end
        end

        if (uart_read_done) begin
            timer_d = '0;
            if (state_q == S_IDLE || byte_cnt_q < LAST_IDX) begin
                asm_d      = w_merged;
                byte_cnt_d = byte_cnt_q + 3'd1;
                state_d    = S_COLLECT;
            end else begin
                w_complete = 1'b1;
                byte_cnt_d = '0;
                state_d    = S_IDLE;
            end
        end else if (state_q == S_COLLECT) begin
            if (TIMEOUT_CYCLES != 0 && timer_q == TIMER_LAST) begin
                w_timeout_hit = 1'b1;
                byte_cnt_d    = '0;
                timer_d       = '0;
                state_d       = S_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (w_complete) begin
            if (!frame_valid_q || frame_ack) begin
                frame_data_d  = w_merged;
                frame_valid_d = 1'b1;
            end else begin
                w_overrun_set = 1'b1;
            end
        end else if (frame_ack && frame_valid_q) begin
            frame_valid_d = 1'b0;
        end

        // A flag that sets in the same cycle as clear_err stays set.
        if (clear_err) begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end
        if (w_overrun_set) begin
            overrun_d = 1'b1;
        end
        if (w_timeout_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
    assign byte_cnt    = byte_cnt_q;
    assign sta         = (state_q == S_COLLECT);

endmodule
`default_nettype wire

// File: doc/uart_frame_rx.md
# uart_frame_rx

- Receive-side framing controller for the PC link.
- Collects bytes from the UART byte receiver into fixed-length frames of FRAME_BYTES bytes, least-significant byte first.
- Each completed frame is presented to the core through a valid/ack holding register.
- Abandons partial frames on an inter-byte timeout and flags overruns when the core does not consume frames in time.

## Interface
Parameters:
- FRAME_BYTES, 5: bytes per frame, range 2-8.
- TIMEOUT_CYCLES, 1000000: idle clk cycles allowed between bytes within a frame; 0 disables the timeout.
- TW, 20: timer width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- uart_read_done  in  1  one-cycle pulse from the byte receiver; read_data is valid in that cycle.
- read_data  in  8  received byte.
- frame_data  out  8*FRAME_BYTES  last accepted frame; the first received byte is bits [7:0].
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ack  in  1  core consumes the frame; acts only while frame_valid=1.
- clear_err  in  1  clears the sticky error flags.
- overrun  out  1  sticky: a completed frame was dropped because the holding register was full.
- timeout_err  out  1  sticky: a partial frame was discarded on timeout.
- byte_cnt  out  3  bytes collected in the current partial frame.
- sta  out  1  collector state: 0=IDLE, 1=COLLECT.

## Operation
- Datapath:
  - Shift/assembly register asm_reg, 8*FRAME_BYTES bits.
  - Byte k of a frame (k=0 first) is written to asm_reg[8k+7:8k].
  - A byte counter and an inter-byte timer.
- IDLE (byte_cnt=0):
  - uart_read_done=1: store byte 0, byte_cnt←1, timer←0, go to COLLECT.
- COLLECT:
  - uart_read_done=1 with byte_cnt<FRAME_BYTES-1: store byte at index byte_cnt, byte_cnt←byte_cnt+1, timer←0.
  - uart_read_done=1 with byte_cnt=FRAME_BYTES-1: this is the last byte.
    - Complete frame = asm_reg merged with the current byte.
    - byte_cnt←0, go to IDLE, hand off to the holding register.
  - No byte, TIMEOUT_CYCLES≠0, timer=TIMEOUT_CYCLES-1: discard the partial frame, byte_cnt←0, timeout_err←1, go to IDLE.
  - No byte otherwise: timer←timer+1.
- Holding register hand-off on completion:
  - frame_valid=0, or frame_valid=1 with frame_ack=1 in the same cycle: frame_data←complete frame, frame_valid←1.
  - frame_valid=1 and frame_ack=0: frame dropped, frame_data unchanged, overrun←1.
- frame_ack=1 with frame_valid=1 and no completion: frame_valid←0; frame_data holds its value.
- frame_ack while frame_valid=0: ignored.
- Error flags:
  - clear_err=1 clears overrun and timeout_err.
  - If an error sets in the same cycle, set wins.
- A byte arriving in the timeout cycle is accepted; no timeout, timer←0.
- The collector never stalls: bytes are always accepted regardless of frame_valid.

## Timing
- Reset (rst=0, asynchronous):
  - frame_data=0, frame_valid=0, overrun=0, timeout_err=0, byte_cnt=0, sta=0.
  - Timer and asm_reg cleared.
  - Reset mid-frame discards the partial frame without flagging timeout_err.
- Latency:
  - Last-byte pulse in cycle N → frame_valid=1 and new frame_data visible at the cycle N+1 edge.
  - One-cycle latency; no extra state.
- frame_ack sampled in cycle M → frame_valid=0 from cycle M+1, unless a completion occurs in cycle M.
- Timeout:
  - Last byte accepted in cycle B, no further bytes → timeout_err=1 and byte_cnt=0 visible from cycle B+TIMEOUT_CYCLES+1.
  - A byte in cycle B+TIMEOUT_CYCLES is still accepted.
- byte_cnt and sta update one cycle after each uart_read_done pulse.
- Back-to-back uart_read_done pulses, one per cycle, are all accepted.

## Test plan
- Frame assembly (FRAME_BYTES=5): bytes 11,22,33,44,55 (hex) with gaps of 100 cycles.
  - frame_valid rises 1 cycle after the 5th pulse.
  - frame_data=0x5544332211.
  - Assert frame_ack → frame_valid drops the next cycle.
- Back-to-back bytes: 5 pulses in consecutive cycles, bytes 01..05.
  - frame_data=0x0504030201.
  - byte_cnt sequence 1,2,3,4,0.
- Timeout (TIMEOUT_CYCLES=50): 3 bytes, then silence.
  - timeout_err=1 and byte_cnt=0 exactly 51 cycles after the 3rd byte.
  - A following frame AA..EE yields frame_data=0xEEDDCCBBAA.
- Overrun: two complete frames, no ack.
  - First frame retained; overrun=1 after the second frame's last byte.
  - clear_err → overrun=0.
  - Repeat with frame_ack in the completion cycle → new frame loaded, frame_valid stays 1, overrun=0.
- Timeout boundary (TIMEOUT_CYCLES=50): byte delivered exactly 50 cycles after the previous one → accepted, no timeout_err.
- Reset mid-frame: assert rst after 2 bytes.
  - All outputs 0, timeout_err=0.
  - A subsequent full frame assembles correctly.
